// File: rtl/rb_pkg.sv
// rtl/rb_pkg.sv - shared constants and FSM state types for the register bank
package rb_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 4;
  localparam int REG_COUNT = 16;
  localparam logic [ADDR_W-1:0] PC_IDX = 4'hF;

  typedef enum logic [1:0] {RD_IDLE, RD_ACCESS, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_t;
endpackage

// File: rtl/register_bank_if.sv
// rtl/register_bank_if.sv - toggle-trigger read and write ports of the register bank
interface register_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] addrIn;
  logic              triggerIn;
  logic [DATA_W-1:0] dataOut;
  logic              readyOut;
  logic [ADDR_W-1:0] wrAddrIn;
  logic [DATA_W-1:0] wrDataIn;
  logic              wrTriggerIn;
  logic              wrReadyOut;

  modport master (
    output addrIn, triggerIn, wrAddrIn, wrDataIn, wrTriggerIn,
    input  dataOut, readyOut, wrReadyOut
  );

  modport slave (
    input  addrIn, triggerIn, wrAddrIn, wrDataIn, wrTriggerIn,
    output dataOut, readyOut, wrReadyOut
  );
endinterface

// File: rtl/register_bank_toggle_req.sv
// rtl/register_bank_toggle_req.sv - toggle-level request detect and gated ready for one port
module toggle_req (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  input  logic set_ready,
  input  logic clr_ready,
  output logic pending,
  output logic ready
);
  logic seen_q;
  logic ready_q;

  // Reset adopts the current level so a held trigger is not mistaken for a request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seen_q  <= trigger;
      ready_q <= 1'b0;
    end else if (set_ready) begin
      seen_q  <= trigger;
      ready_q <= 1'b1;
    end else if (clr_ready) begin
      ready_q <= 1'b0;
    end
  end

  assign pending = trigger ^ seen_q;
  assign ready   = ready_q & ~pending;
endmodule

// File: rtl/register_bank.sv
// rtl/register_bank.sv - 16x32 register bank with independent toggle-handshake read and write ports
// Optional RB_WRITE_BYPASS_EN: same-edge read/write of one register returns the new data.
module register_bank #(
  parameter int                DATA_W    = rb_pkg::DATA_W,
  parameter int                ADDR_W    = rb_pkg::ADDR_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic             clk,
  input logic             reset,
  register_bank_if.slave  bus
);
  import rb_pkg::*;

  logic [DATA_W-1:0] regs [REG_COUNT];

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rd_word;

  logic rd_pending, rd_set, rd_clr, rd_latch;
  logic wr_pending, wr_set, wr_clr, wr_latch;

  toggle_req u_rd_req (
    .clk       (clk),
    .reset     (reset),
    .trigger   (bus.triggerIn),
    .set_ready (rd_set),
    .clr_ready (rd_clr),
    .pending   (rd_pending),
    .ready     (bus.readyOut)
  );

  toggle_req u_wr_req (
    .clk       (clk),
    .reset     (reset),
    .trigger   (bus.wrTriggerIn),
    .set_ready (wr_set),
    .clr_ready (wr_clr),
    .pending   (wr_pending),
    .ready     (bus.wrReadyOut)
  );

  always_comb begin
    rd_next  = rd_state;
    rd_latch = 1'b0;
    rd_set   = 1'b0;
    rd_clr   = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (rd_pending) begin
          rd_latch = 1'b1;
          rd_next  = RD_ACCESS;
        end
      end
      RD_ACCESS: begin
        rd_set  = 1'b1;
        rd_next = RD_RESP;
      end
      RD_RESP: begin
        if (rd_pending) begin
          rd_clr   = 1'b1;
          rd_latch = 1'b1;
          rd_next  = RD_ACCESS;
        end
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_next  = wr_state;
    wr_latch = 1'b0;
    wr_set   = 1'b0;
    wr_clr   = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (wr_pending) begin
          wr_latch = 1'b1;
          wr_next  = WR_COMMIT;
        end
      end
      WR_COMMIT: begin
        wr_set  = 1'b1;
        wr_next = WR_RESP;
      end
      WR_RESP: begin
        if (wr_pending) begin
          wr_clr   = 1'b1;
          wr_latch = 1'b1;
          wr_next  = WR_COMMIT;
        end
      end
      default: wr_next = WR_IDLE;
    endcase
  end

`ifdef RB_WRITE_BYPASS_EN
  assign rd_word = (wr_set && (wr_addr_q == rd_addr_q)) ? wr_data_q : regs[rd_addr_q];
`else
  assign rd_word = regs[rd_addr_q];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_state  <= RD_IDLE;
      wr_state  <= WR_IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      data_q    <= '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
      if (rd_latch) begin
        rd_addr_q <= bus.addrIn;
      end
      if (wr_latch) begin
        wr_addr_q <= bus.wrAddrIn;
        wr_data_q <= bus.wrDataIn;
      end
      if (rd_set) begin
        data_q <= rd_word;
      end
      // R15 (PC_IDX) gets no special treatment; it is written like any other register.
      if (wr_set) begin
        regs[wr_addr_q] <= wr_data_q;
      end
    end
  end

  assign bus.dataOut = data_q;
endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - randomized self-checking bench for register_bank against an array model
module tb_register_bank;
  logic clk;
  logic reset;

  register_bank_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  register_bank dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model [16];
  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  task automatic do_read(input logic [3:0] a);
    @(negedge clk);
    bus.addrIn    = a;
    bus.triggerIn = ~bus.triggerIn;
    #1 check("rd_drop", {31'b0, bus.readyOut}, 32'd0);
    @(negedge clk);
    check("rd_busy", {31'b0, bus.readyOut}, 32'd0);
    @(negedge clk);
    check("rd_ready", {31'b0, bus.readyOut}, 32'd1);
    check("rd_data", bus.dataOut, model[a]);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.wrAddrIn    = a;
    bus.wrDataIn    = d;
    bus.wrTriggerIn = ~bus.wrTriggerIn;
    #1 check("wr_drop", {31'b0, bus.wrReadyOut}, 32'd0);
    @(negedge clk);
    check("wr_busy", {31'b0, bus.wrReadyOut}, 32'd0);
    @(negedge clk);
    check("wr_ready", {31'b0, bus.wrReadyOut}, 32'd1);
    model[a] = d;
  endtask

  // Read and write requested on the same edge; equal addresses collide at commit.
  task automatic do_rw(input logic [3:0] ra, input logic [3:0] wa, input logic [31:0] wd);
    logic [31:0] exp_rd;
    exp_rd = model[ra];
`ifdef RB_WRITE_BYPASS_EN
    if (ra == wa) exp_rd = wd;
`endif
    @(negedge clk);
    bus.addrIn      = ra;
    bus.wrAddrIn    = wa;
    bus.wrDataIn    = wd;
    bus.triggerIn   = ~bus.triggerIn;
    bus.wrTriggerIn = ~bus.wrTriggerIn;
    @(negedge clk);
    @(negedge clk);
    check("rw_rd_ready", {31'b0, bus.readyOut}, 32'd1);
    check("rw_wr_ready", {31'b0, bus.wrReadyOut}, 32'd1);
    check("rw_rd_data", bus.dataOut, exp_rd);
    model[wa] = wd;
  endtask

  initial begin
    int pulses;
    logic prev_rdy;
    logic [3:0] a;
    n_tests = 0;
    n_fail  = 0;
    model_reset();

    // Reset while the read trigger sits high: the held level must not be a request.
    reset           = 1'b0;
    bus.addrIn      = '0;
    bus.triggerIn   = 1'b1;
    bus.wrAddrIn    = '0;
    bus.wrDataIn    = '0;
    bus.wrTriggerIn = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_ready", {31'b0, bus.readyOut}, 32'd0);
      check("rst_wready", {31'b0, bus.wrReadyOut}, 32'd0);
    end
    check("rst_data", bus.dataOut, 32'd0);
    for (int i = 0; i < 16; i++) do_read(i[3:0]);

    do_write(4'd3, 32'hDEADBEEF);
    do_read(4'd3);

    // Back-to-back: R15 then R3, second toggle while ready is high.
    do_write(4'd15, 32'h0000_1234);
    do_read(4'd15);
    do_read(4'd3);

    // Write at edge N, read sampled at N+1 accesses at N+2 and sees the new value.
    @(negedge clk);
    bus.wrAddrIn    = 4'd7;
    bus.wrDataIn    = 32'hA5A5_0007;
    bus.wrTriggerIn = ~bus.wrTriggerIn;
    model[7]        = 32'hA5A5_0007;
    do_read(4'd7);

    do_write(4'd5, 32'd1);
    do_rw(4'd5, 4'd5, 32'd2);
    do_read(4'd5);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: do_read(4'($urandom_range(0, 15)));
        1: do_write(4'($urandom_range(0, 15)), $urandom);
        default: do_rw(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
      endcase
    end

    // Double toggle before ready: exactly one response, for the first address.
    a = 4'($urandom_range(0, 15));
    @(negedge clk);
    bus.addrIn    = a;
    bus.triggerIn = ~bus.triggerIn;
    @(negedge clk);
    bus.triggerIn = ~bus.triggerIn;
    pulses   = 0;
    prev_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.readyOut && !prev_rdy) pulses++;
      prev_rdy = bus.readyOut;
      check("dbl_high", {31'b0, bus.readyOut}, 32'd1);
    end
    check("dbl_pulses", pulses, 32'd1);
    check("dbl_data", bus.dataOut, model[a]);

    // Reset while in RD_ACCESS: request dropped, registers cleared.
    do_write(4'd9, 32'h9999_0009);
    @(negedge clk);
    bus.addrIn    = 4'd9;
    bus.triggerIn = ~bus.triggerIn;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_ready", {31'b0, bus.readyOut}, 32'd0);
    end
    for (int i = 0; i < 16; i++) do_read(i[3:0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/register_bank.md
# register_bank

Clocked 16 x 32-bit register bank serving as the responder on the decode stage's register-read interface and the writeback stage's register-write interface. Both interfaces use the pipeline's toggle-trigger/ready handshake: the initiator drives an address (and data for writes), flips a trigger level and waits for ready. The bank serves one outstanding read and one outstanding write concurrently. R15 is the PC and is read and written like any other register.

## Interface

Parameters:
- DATA_W, 32, register width
- ADDR_W, 4, register index width
- RESET_VAL, 32'h0, value of every register after reset

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- addrIn  in  ADDR_W  read register index; stable from trigger toggle until readyOut
- triggerIn  in  1  read request; every level change is one request
- dataOut  out  DATA_W  read data; valid while readyOut=1
- readyOut  out  1  read response ready
- wrAddrIn  in  ADDR_W  write register index
- wrDataIn  in  DATA_W  write data
- wrTriggerIn  in  1  write request; every level change is one request
- wrReadyOut  out  1  write committed

## Operation

- Read FSM states:
  - RD_IDLE: rdSeen_q == triggerIn. On a mismatch, latch addrIn into rdAddr_q and go to RD_ACCESS.
  - RD_ACCESS: dataOut <= regs[rdAddr_q], rdSeen_q <= triggerIn, rdReady_q <= 1, go to RD_RESP.
  - RD_RESP: on a mismatch, rdReady_q <= 0, latch addrIn and go to RD_ACCESS. Otherwise hold.
- readyOut = rdReady_q & (triggerIn == rdSeen_q). It drops combinationally in the same cycle the initiator toggles. The initiator therefore never observes a stale ready after issuing a new request.
- Write FSM mirrors the read FSM with states WR_IDLE, WR_COMMIT and WR_RESP:
  - On a wrTriggerIn mismatch, latch wrAddrIn and wrDataIn.
  - WR_COMMIT writes regs[addr], updates wrSeen_q and sets wrReady_q.
  - wrReadyOut = wrReady_q & (wrTriggerIn == wrSeen_q).
- Read and write FSMs are fully independent, and both may be active in the same cycle.
- Read and write hitting the same register on the same edge (RD_ACCESS and WR_COMMIT coincide): see Configuration.
- A second toggle before the ready for the first is a protocol violation. The bank completes the in-flight access with rdSeen_q set to the current level, so at most one response is produced.
- Reset (reset=0 at an edge):
  - regs <= RESET_VAL, dataOut <= 0.
  - rdReady_q and wrReady_q <= 0, so readyOut=0 and wrReadyOut=0.
  - FSMs return to their IDLE states.
  - rdSeen_q <= triggerIn and wrSeen_q <= wrTriggerIn, so the current trigger levels are not treated as requests.
  - Reset asserted mid-operation drops the pending request with no response; the initiator must re-toggle after reset.

## Timing

- Read latency: toggle sampled at edge N produces dataOut and readyOut=1 after edge N+1. A toggle present while in RD_RESP follows the same N to N+1 timing.
- Write latency: toggle sampled at edge N commits at edge N+1 with wrReadyOut=1. A read whose RD_ACCESS is at edge N+2 or later sees the new value.
- Throughput: one read and one write every 2 cycles, given an immediate re-toggle.
- readyOut and wrReadyOut each have a combinational path from their own trigger input only, to the low level.
- addrIn, wrAddrIn and wrDataIn are sampled only at the mismatch edge.

## Configuration

- RB_WRITE_BYPASS_EN defined:
  - When RD_ACCESS and WR_COMMIT occur on the same edge with rdAddr_q == wrAddr_q, dataOut takes the latched write data (write-first).
- Undefined:
  - dataOut returns the pre-write register value (read-first).
  - The write still commits.

## Structure

- Package rb_pkg holds:
  - DATA_W, ADDR_W, REG_COUNT=16, PC_IDX=4'hF
  - rd_state_t {RD_IDLE, RD_ACCESS, RD_RESP}
  - wr_state_t {WR_IDLE, WR_COMMIT, WR_RESP}
- Sub-module toggle_req is instantiated once per port. It holds the seen-level register, the mismatch detect, the ready register, and the combinational ready gating.

## Test plan

- Reset with triggerIn=1, then release -> no read serviced, readyOut=0, reading any register returns 0.
- Write R3=32'hDEADBEEF via a wrTriggerIn toggle -> wrReadyOut=1 one edge after the sampled toggle; a subsequent read of R3 returns 32'hDEADBEEF with readyOut=1 after 2 edges.
- Back-to-back reads R15 then R3: second toggle while readyOut=1 -> readyOut falls in the same cycle, rises again 2 edges later with the R3 data.
- Same-edge read and write of R5 (old 1, new 2) -> dataOut=2 with RB_WRITE_BYPASS_EN, 1 without; R5=2 afterwards in both builds.
- Assert reset in RD_ACCESS -> no readyOut pulse and R0..R15 all 0; a fresh toggle after release is serviced normally.
- Double toggle before ready -> exactly one readyOut assertion, and readyOut stays high while the trigger is stable.
